cpu_control_unit: RTL and testbench

CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

---
 rtl/cpu_control_unit_pkg.sv | 21 ++
 rtl/cpu_control_unit_if.sv | 24 ++
 rtl/cpu_control_unit_dec3to8.sv | 10 +
 rtl/cpu_control_unit.sv | 108 ++++++++++
 tb/tb_cpu_control_unit.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/cpu_control_unit_pkg.sv
// Shared definitions for the control unit: FSM step encoding and opcode constants.
package cpu_pkg;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   // add and sub are the only opcodes that go through the ALU in T2/T3
   function automatic logic is_alu(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Signal bundle between the sequencer and its datapath; master drives run/din.
interface cpu_control_unit_if;
   logic        run;
   logic [15:0] din;
   logic [7:0]  rin;
   logic [2:0]  rout;
   logic        din_en;
   logic        gout;
   logic        ain;
   logic        gin;
   logic        addsub;
   logic        irin;
   logic        done;

   modport master (
      output run, din,
      input  rin, rout, din_en, gout, ain, gin, addsub, irin, done
   );

   modport slave (
      input  run, din,
      output rin, rout, din_en, gout, ain, gin, addsub, irin, done
   );
endinterface

// File: rtl/cpu_control_unit_dec3to8.sv
// Enabled 3-to-8 one-hot decoder driving the register load strobes.
module dec3to8 (
   input  logic       en_i,
   input  logic [2:0] idx_i,
   output logic [7:0] onehot_o
);
   for (genvar i = 0; i < 8; i++) begin : g_bit
      assign onehot_o[i] = en_i && (idx_i == 3'(i));
   end
endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer for the mv/mvi/add/sub processor; outputs are pure
// decodes of the current step, the latched instruction and run.
module cpu_control_unit
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        run,
   input  logic [15:0] din,
   output logic [7:0]  rin,
   output logic [2:0]  rout,
   output logic        din_en,
   output logic        gout,
   output logic        ain,
   output logic        gin,
   output logic        addsub,
   output logic        irin,
   output logic        done
);

   state_t     state_q, state_d;
   logic [8:0] ir_q, ir_d;
   logic       rin_en;

   logic [2:0] opc, rx, ry;
   assign opc = ir_q[8:6];
   assign rx  = ir_q[5:3];
   assign ry  = ir_q[2:0];

   logic unused_din;
   assign unused_din = ^din[15:9];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= T0;
         ir_q    <= 9'd0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         T0: if (run) begin
            state_d = T1;
            ir_d    = din[8:0];
         end
         T1: state_d = is_alu(opc) ? T2 : T0;
         T2: state_d = T3;
         T3: state_d = T0;
      endcase
   end

   always_comb begin
      rin_en = 1'b0;
      rout   = 3'd0;
      din_en = 1'b0;
      gout   = 1'b0;
      ain    = 1'b0;
      gin    = 1'b0;
      addsub = 1'b0;
      irin   = 1'b0;
      done   = 1'b0;
      case (state_q)
         // reset forces T0 asynchronously, so gating irin keeps every output low in reset
         T0: irin = run & resetn;
         T1: begin
            case (opc)
               OP_MV: begin
                  rout   = ry;
                  rin_en = 1'b1;
                  done   = 1'b1;
               end
               OP_MVI: begin
                  din_en = 1'b1;
                  rin_en = 1'b1;
                  done   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  rout = rx;
                  ain  = 1'b1;
               end
               default: done = 1'b1;
            endcase
         end
         T2: begin
            rout   = ry;
            gin    = 1'b1;
            addsub = (opc == OP_SUB);
         end
         T3: begin
            gout   = 1'b1;
            rin_en = 1'b1;
            done   = 1'b1;
         end
      endcase
   end

   dec3to8 u_rin_dec (
      .en_i     (rin_en),
      .idx_i    (rx),
      .onehot_o (rin)
   );

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench: stimulus pushes per-cycle expected control words derived
// from instruction semantics; a negedge monitor pops and compares.
module tb_cpu_control_unit;

   typedef struct packed {
      logic [7:0] rin;
      logic [2:0] rout;
      logic       din_en;
      logic       gout;
      logic       ain;
      logic       gin;
      logic       addsub;
      logic       irin;
      logic       done;
   } exp_t;

   typedef struct {
      exp_t  v;
      string tag;
   } sb_item_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   total = 0;
   int   bad = 0;
   sb_item_t sb[$];

   cpu_control_unit_if bus ();

   always #5 clk = ~clk;

   cpu_control_unit dut (
      .clk    (clk),
      .resetn (resetn),
      .run    (bus.run),
      .din    (bus.din),
      .rin    (bus.rin),
      .rout   (bus.rout),
      .din_en (bus.din_en),
      .gout   (bus.gout),
      .ain    (bus.ain),
      .gin    (bus.gin),
      .addsub (bus.addsub),
      .irin   (bus.irin),
      .done   (bus.done)
   );

   // Reference: what each cycle of an instruction must show, by opcode meaning.
   function automatic int instr_len(input logic [2:0] op);
      return (op == 3'b010 || op == 3'b011) ? 4 : 2;
   endfunction

   function automatic exp_t step_exp(input logic [2:0] op, input logic [2:0] rx,
                                     input logic [2:0] ry, input int k);
      exp_t e;
      e = '0;
      if (k == 0) begin
         e.irin = 1'b1;
      end else if (op == 3'b000) begin
         e.rout = ry; e.rin = 8'(1) << rx; e.done = 1'b1;
      end else if (op == 3'b001) begin
         e.din_en = 1'b1; e.rin = 8'(1) << rx; e.done = 1'b1;
      end else if (op == 3'b010 || op == 3'b011) begin
         if (k == 1) begin
            e.rout = rx; e.ain = 1'b1;
         end else if (k == 2) begin
            e.rout = ry; e.gin = 1'b1; e.addsub = (op == 3'b011);
         end else begin
            e.gout = 1'b1; e.rin = 8'(1) << rx; e.done = 1'b1;
         end
      end else begin
         e.done = 1'b1;
      end
      return e;
   endfunction

   task automatic cyc(input logic rst_n, input logic r, input logic [15:0] d,
                      input exp_t e, input string tag);
      sb_item_t it;
      @(posedge clk);
      #1;
      resetn  = rst_n;
      bus.run = r;
      bus.din = d;
      it.v   = e;
      it.tag = tag;
      sb.push_back(it);
   endtask

   task automatic run_instr(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                            input logic [15:0] imm, input bit hold_run, input string tag);
      logic [15:0] d;
      logic        r;
      for (int k = 0; k < instr_len(op); k++) begin
         if (k == 0) begin
            d = {7'($urandom), op, rx, ry};
            r = 1'b1;
         end else begin
            d = (op == 3'b001 && k == 1) ? imm : 16'($urandom);
            r = hold_run ? 1'b1 : 1'($urandom);
         end
         cyc(1'b1, r, d, step_exp(op, rx, ry, k), $sformatf("%s_c%0d", tag, k));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cyc(1'b1, 1'b0, 16'($urandom), '0, "idle");
   endtask

   initial begin : monitor
      sb_item_t it;
      exp_t     act;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            it  = sb.pop_front();
            act = {bus.rin, bus.rout, bus.din_en, bus.gout, bus.ain, bus.gin,
                   bus.addsub, bus.irin, bus.done};
            total++;
            if (act !== it.v) begin
               bad++;
               $display("FAIL %s: got rin=%h rout=%0d den=%b gout=%b ain=%b gin=%b as=%b irin=%b done=%b want rin=%h rout=%0d den=%b gout=%b ain=%b gin=%b as=%b irin=%b done=%b",
                        it.tag, act.rin, act.rout, act.din_en, act.gout, act.ain, act.gin,
                        act.addsub, act.irin, act.done, it.v.rin, it.v.rout, it.v.din_en,
                        it.v.gout, it.v.ain, it.v.gin, it.v.addsub, it.v.irin, it.v.done);
            end
         end
      end
   end

   initial begin : stim
      exp_t z;
      z = '0;
      bus.run = 1'b0;
      bus.din = 16'd0;

      // reset with run high: everything quiet
      cyc(1'b0, 1'b1, 16'hffff, z, "rst_run_hi0");
      cyc(1'b0, 1'b1, 16'h00ab, z, "rst_run_hi1");

      // first T0 after release is the instruction fetch of mv r2,r5
      run_instr(3'b000, 3'd2, 3'd5, 16'h0, 1'b0, "mv_r2_r5");
      idle(1);
      run_instr(3'b001, 3'd7, 3'd0, 16'h1234, 1'b0, "mvi_r7");
      run_instr(3'b011, 3'd1, 3'd6, 16'h0, 1'b0, "sub_r1_r6");
      run_instr(3'b010, 3'd3, 3'd3, 16'h0, 1'b0, "add_r3_r3");

      // reset pulsed during T2 of add: no load strobe may follow
      cyc(1'b1, 1'b1, {7'd0, 3'b010, 3'd4, 3'd2}, step_exp(3'b010, 3'd4, 3'd2, 0), "rstadd_c0");
      cyc(1'b1, 1'b1, 16'($urandom), step_exp(3'b010, 3'd4, 3'd2, 1), "rstadd_c1");
      cyc(1'b0, 1'b1, 16'($urandom), z, "rstadd_t2");
      cyc(1'b0, 1'b1, 16'($urandom), z, "rstadd_hold");
      cyc(1'b1, 1'b0, 16'($urandom), z, "rstadd_rel");
      idle(1);
      run_instr(3'b000, 3'd0, 3'd1, 16'h0, 1'b0, "mv_after_rst");

      // NOP then mv with run held high: done in cycles 2/4, irin in 1/3
      run_instr(3'b110, 3'd5, 3'd5, 16'h0, 1'b1, "nop110");
      run_instr(3'b000, 3'd6, 3'd4, 16'h0, 1'b1, "mv_after_nop");

      for (int n = 0; n < 80; n++) begin
         run_instr(3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom),
                   1'($urandom), $sformatf("rnd%0d", n));
         idle(int'($urandom_range(0, 2)));
      end

      idle(1);
      repeat (3) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
